// File: rtl/bs_frame_ctrl.sv
// bs_frame_ctrl: shifts a parallel operand into a bit-serial datapath and reassembles the serial result.
// Optional macro BS_FRAME_CARRY_EN adds out_carry, the datapath carry captured one cycle after the last bit.
module bs_frame_ctrl #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             bs_a,
  output logic             bs_isync,
  input  logic             bs_q,
  input  logic             bs_osync,
  input  logic             bs_ocarry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
`ifdef BS_FRAME_CARRY_EN
  output logic             out_carry,
`endif
  output logic             err_tmo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_WAIT, S_COLLECT, S_CARRY, S_HOLD
  } state_t;

`ifdef BS_FRAME_CARRY_EN
  localparam state_t DONE_ST = S_CARRY;
`else
  localparam state_t DONE_ST = S_HOLD;
`endif

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_shreg, r_res, r_out_data;
  logic [CW-1:0]    r_bitcnt, r_colcnt;
  logic [TW-1:0]    r_tmo;
  logic             r_seen;
  logic             w_active, w_start, w_cap, w_last, w_tmo;

  // The collector listens from the first SEND cycle, so a short datapath may return bits while still sending.
  assign w_active = (r_state == S_SEND) || (r_state == S_WAIT) || (r_state == S_COLLECT);
  assign w_start  = w_active && !r_seen && bs_osync;
  assign w_cap    = w_start || (w_active && r_seen && (r_colcnt != FULL));
  assign w_last   = w_cap && (r_colcnt == LAST);
  assign w_tmo    = ((r_state == S_SEND) || (r_state == S_WAIT)) && !r_seen && (r_tmo == TMAX);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values, regardless of statement order.
    if (reset) begin
      r_state    <= S_IDLE;
      r_shreg    <= '0;
      r_res      <= '0;
      r_out_data <= '0;
      r_bitcnt   <= '0;
      r_colcnt   <= '0;
      r_tmo      <= '0;
      r_seen     <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && in_valid) begin
        r_shreg  <= in_data;
        r_bitcnt <= '0;
        r_colcnt <= '0;
        r_tmo    <= '0;
        r_seen   <= 1'b0;
      end else begin
        if (r_state == S_SEND) begin
          r_shreg <= r_shreg >> 1;
          if (r_bitcnt != FULL) r_bitcnt <= r_bitcnt + 1'b1;
        end
        if (w_active && !r_seen && (r_tmo != TMAX)) r_tmo <= r_tmo + 1'b1;
        if (w_start) r_seen <= 1'b1;
        if (w_cap) begin
          r_res    <= {bs_q, r_res[WIDTH-1:1]};
          r_colcnt <= r_colcnt + 1'b1;
        end
        if (w_last) r_out_data <= {bs_q, r_res[WIDTH-1:1]};
      end
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns w_next and no latch is inferred.
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (in_valid) w_next = S_SEND;
      S_SEND: begin
        if (w_tmo)                   w_next = S_IDLE;
        else if (w_last)             w_next = DONE_ST;
        else if (r_bitcnt == LAST)   w_next = (r_seen || w_start) ? S_COLLECT : S_WAIT;
      end
      S_WAIT: begin
        if (w_tmo)        w_next = S_IDLE;
        else if (w_start) w_next = S_COLLECT;
      end
      S_COLLECT: if (w_last) w_next = DONE_ST;
      S_CARRY:   w_next = S_HOLD;
      S_HOLD:    if (out_ready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    bs_a      = 1'b0;
    bs_isync  = 1'b0;
    out_valid = 1'b0;
    err_tmo   = 1'b0;
    if (!reset) begin
      in_ready  = (r_state == S_IDLE);
      out_valid = (r_state == S_HOLD);
      err_tmo   = w_tmo;
      if (r_state == S_SEND) begin
        bs_a     = r_shreg[0];
        bs_isync = (r_bitcnt == '0);
      end
    end
  end

  assign out_data = r_out_data;

`ifdef BS_FRAME_CARRY_EN
  logic r_out_carry;
  always_ff @(posedge clk) begin
    if (reset)                  r_out_carry <= 1'b0;
    else if (r_state == S_CARRY) r_out_carry <= bs_ocarry;
  end
  assign out_carry = r_out_carry;
`else
  logic w_unused_ocarry;
  assign w_unused_ocarry = bs_ocarry;
`endif

endmodule

// File: tb/tb_bs_frame_ctrl.sv
// Directed bench for bs_frame_ctrl with a stub serial datapath of adjustable delay (q<=a, osync<=isync).
// Define BS_FRAME_CARRY_EN for both files to exercise out_carry.
`timescale 1ns/1ps
module tb_bs_frame_ctrl;
  localparam int WIDTH   = 8;
  localparam int TIMEOUT = 64;
`ifdef BS_FRAME_CARRY_EN
  localparam int CX = 1;
`else
  localparam int CX = 0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready, bs_a, bs_isync, bs_q, bs_osync, bs_ocarry, out_valid, err_tmo;
  logic [WIDTH-1:0] out_data;
`ifdef BS_FRAME_CARRY_EN
  logic             out_carry;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Stub datapath: lat cycles of delay, osync can be suppressed or a stray pulse injected.
  logic [15:0] pipe_a = '0;
  logic [15:0] pipe_s = '0;
  int          lat = 1;
  logic        osync_en = 1'b1;
  logic        stray = 1'b0;
  logic        carry_in = 1'b0;
  logic        stub_carry = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    pipe_a     <= {pipe_a[14:0], bs_a};
    pipe_s     <= {pipe_s[14:0], bs_isync & osync_en};
    stub_carry <= carry_in;
  end
  assign bs_q      = pipe_a[lat-1];
  assign bs_osync  = pipe_s[lat-1] | stray;
  assign bs_ocarry = stub_carry;

  bs_frame_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .bs_a(bs_a), .bs_isync(bs_isync), .bs_q(bs_q), .bs_osync(bs_osync), .bs_ocarry(bs_ocarry),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef BS_FRAME_CARRY_EN
    .out_carry(out_carry),
`endif
    .err_tmo(err_tmo)
  );

  // Handshake one operand; returns at the negedge of the first SEND cycle.
  task automatic send_operand(input logic [WIDTH-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts negedges from the first SEND cycle until out_valid, bounded.
  task automatic wait_out_valid(output int k);
    k = 0;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_low: got %b want 0", in_ready); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send_operand(8'h5A);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (in_ready || bs_a || bs_isync || out_valid || err_tmo) bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL reset_outputs_low: %0d bad cycles want 0", bad); end
    reset = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    n_tests++;
    if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (!in_ready || bs_a || bs_isync || out_valid || err_tmo) bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL reset_quiet_after: %0d bad cycles want 0", bad); end
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] d = 8'hA5;
    logic [WIDTH-1:0] got_a = '0, got_s = '0;
    int bad = 0;
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_idle: got %b want 1", in_ready); end
    send_operand(d);
    for (int i = 0; i < WIDTH; i++) begin
      got_a[i] = bs_a;
      got_s[i] = bs_isync;
      if (in_ready) bad++;
      @(negedge clk);
    end
    n_tests++;
    if (got_a !== 8'hA5) begin n_fail++; $display("FAIL basic_bs_a_seq: got %h want a5", got_a); end
    n_tests++;
    if (got_s !== 8'h01) begin n_fail++; $display("FAIL basic_isync_seq: got %h want 01", got_s); end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL basic_ready_send: %0d cycles high want 0", bad); end
    n_tests++;
    if (bs_a !== 1'b0 || bs_isync !== 1'b0 || out_valid !== 1'b0)
      begin n_fail++; $display("FAIL basic_after_send: a=%b sync=%b ov=%b want 0 0 0", bs_a, bs_isync, out_valid); end
    repeat (CX + 1) @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5)
      begin n_fail++; $display("FAIL basic_result: ov=%b data=%h want 1 a5", out_valid, out_data); end
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin n_fail++; $display("FAIL basic_release: ov=%b rdy=%b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_back_to_back();
    int k, bad = 0;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h01;
    @(negedge clk);
    in_data  = 8'hFF;
    k = 0;
    while (!out_valid && k < 100) begin
      if (in_ready) bad++;
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (k != WIDTH + lat + CX || out_data !== 8'h01)
      begin n_fail++; $display("FAIL b2b_first: k=%0d data=%h want %0d 01", k, out_data, WIDTH + lat + CX); end
    n_tests++;
    if (bad != 0 || in_ready !== 1'b0)
      begin n_fail++; $display("FAIL b2b_ready_low: %0d bad, hold rdy=%b want 0 0", bad, in_ready); end
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_idle: got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    wait_out_valid(k);
    n_tests++;
    if (k != WIDTH + lat + CX || out_data !== 8'hFF)
      begin n_fail++; $display("FAIL b2b_second: k=%0d data=%h want %0d ff", k, out_data, WIDTH + lat + CX); end
    @(negedge clk);
  endtask

  task automatic test_hold_stall();
    int k, bad = 0;
    out_ready = 1'b0;
    @(negedge clk);
    send_operand(8'h3C);
    wait_out_valid(k);
    n_tests++;
    if (k != WIDTH + lat + CX) begin n_fail++; $display("FAIL stall_latency: got %0d want %0d", k, WIDTH + lat + CX); end
    for (int i = 0; i < 10; i++) begin
      if (!out_valid || out_data !== 8'h3C || in_ready) bad++;
      @(negedge clk);
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL stall_stable: %0d bad cycles want 0", bad); end
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin n_fail++; $display("FAIL stall_release: ov=%b rdy=%b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_timeout();
    int k, nv = 0;
    osync_en  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    send_operand(8'hC3);
    k = 1;
    while (!err_tmo && k < 200) begin
      @(negedge clk);
      k++;
      if (out_valid) nv++;
    end
    n_tests++;
    if (k != TIMEOUT + 1) begin n_fail++; $display("FAIL tmo_cycle: pulse at SEND cycle %0d want %0d", k, TIMEOUT + 1); end
    @(negedge clk);
    if (out_valid) nv++;
    n_tests++;
    if (err_tmo !== 1'b0 || in_ready !== 1'b1)
      begin n_fail++; $display("FAIL tmo_one_pulse: err=%b rdy=%b want 0 1", err_tmo, in_ready); end
    n_tests++;
    if (nv != 0) begin n_fail++; $display("FAIL tmo_no_valid: %0d valid cycles want 0", nv); end
    osync_en = 1'b1;
  endtask

  task automatic test_long_latency();
    int k;
    repeat (16) @(negedge clk);
    lat = 12;
    send_operand(8'h4B);
    wait_out_valid(k);
    n_tests++;
    if (k != WIDTH + 12 + CX || out_data !== 8'h4B)
      begin n_fail++; $display("FAIL long_lat: k=%0d data=%h want %0d 4b", k, out_data, WIDTH + 12 + CX); end
    @(negedge clk);
    repeat (16) @(negedge clk);
    lat = 1;
  endtask

  task automatic test_stray_sync();
    int k = 0;
    @(negedge clk);
    stray = 1'b1;
    send_operand(8'h96);
    stray = 1'b0;
    while (!out_valid && k < 100) begin
      stray = (k == 4);
      @(negedge clk);
      k++;
    end
    stray = 1'b0;
    n_tests++;
    if (k != WIDTH + lat + CX || out_data !== 8'h96)
      begin n_fail++; $display("FAIL stray_sync: k=%0d data=%h want %0d 96", k, out_data, WIDTH + lat + CX); end
    @(negedge clk);
  endtask

`ifdef BS_FRAME_CARRY_EN
  task automatic test_carry();
    int k;
    carry_in = 1'b1;
    @(negedge clk);
    send_operand(8'h81);
    wait_out_valid(k);
    n_tests++;
    if (k != WIDTH + lat + 1 || out_data !== 8'h81 || out_carry !== 1'b1)
      begin n_fail++; $display("FAIL carry_one: k=%0d data=%h c=%b want %0d 81 1", k, out_data, out_carry, WIDTH + lat + 1); end
    @(negedge clk);
    carry_in = 1'b0;
    send_operand(8'h7E);
    wait_out_valid(k);
    n_tests++;
    if (out_data !== 8'h7E || out_carry !== 1'b0)
      begin n_fail++; $display("FAIL carry_zero: data=%h c=%b want 7e 0", out_data, out_carry); end
    @(negedge clk);
  endtask
`endif

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_hold_stall();
    test_timeout();
    test_long_latency();
    test_stray_sync();
`ifdef BS_FRAME_CARRY_EN
    test_carry();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
